// File: rtl/axi4_arbiter_2to1.sv
// axi4_arbiter_2to1
// Shares one AXI4 slave port between two AXI4 masters (m0 = IFU, m1 = LSU).
// The read (AR/R) and write (AW/W/B) paths are arbitrated independently. Each
// path carries one transaction at a time. The grant is registered in IDLE and
// stays locked until the final R beat or the B handshake, so bursts never
// interleave.
//
// Ports
//   clock, reset_n   : clock (rising edge) and asynchronous active-low reset
//   mX_ar* / mX_r*   : read address / read data channels of master X (X = 0, 1)
//   mX_aw* / mX_w*   : write address / write data channels of master X
//   mX_b*            : write response channel of master X
//   s_ar*/s_aw*/s_w* : muxed request channels towards the slave
//   s_r* / s_b*      : response channels from the slave
//
// Configuration
//   AXI4_ARB_RR_EN defined   : round-robin, on contention the master that did
//                              not finish last wins
//   AXI4_ARB_RR_EN undefined : fixed priority, m0 wins over m1
module axi4_arbiter_2to1 #(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    // master 0
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [ID_W-1:0]     m0_rid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [ID_W-1:0]     m0_bid,
    output logic [1:0]          m0_bresp,
    // master 1
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [ID_W-1:0]     m1_rid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [ID_W-1:0]     m1_bid,
    output logic [1:0]          m1_bresp,
    // slave
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ID_W-1:0]     s_arid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [ID_W-1:0]     s_rid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    input  logic                s_rlast,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ID_W-1:0]     s_awid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    output logic [1:0]          s_awburst,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [ID_W-1:0]     s_bid,
    input  logic [1:0]          s_bresp
);

    typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;
    typedef enum logic [1:0] {WrIdle, WrAddr, WrData, WrResp} wr_state_e;

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    // Grant / last-served encoding: 0 = m0, 1 = m1.
    logic      rd_gnt_q, rd_gnt_d, rd_last_q, rd_last_d;
    logic      wr_gnt_q, wr_gnt_d, wr_last_q, wr_last_d;
    logic      rd_pick, wr_pick;

    // A lone requester always wins; only contention consults the policy.
    always_comb begin
        rd_pick = m1_arvalid & ~m0_arvalid;
        wr_pick = m1_awvalid & ~m0_awvalid;
`ifdef AXI4_ARB_RR_EN
        if (m0_arvalid && m1_arvalid) rd_pick = ~rd_last_q;
        if (m0_awvalid && m1_awvalid) wr_pick = ~wr_last_q;
`endif
    end

`ifndef AXI4_ARB_RR_EN
    // Last-served history is kept up to date but not consulted by fixed priority.
    logic unused_last;
    assign unused_last = rd_last_q ^ wr_last_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q <= RdIdle;
            wr_state_q <= WrIdle;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_last_q  <= 1'b1;
            wr_last_q  <= 1'b1;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_last_q  <= rd_last_d;
            wr_last_q  <= wr_last_d;
        end
    end

    // Read path next state
    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_last_d  = rd_last_q;
        unique case (rd_state_q)
            RdIdle: if (m0_arvalid || m1_arvalid) begin
                rd_gnt_d   = rd_pick;
                rd_state_d = RdAddr;
            end
            RdAddr: if (s_arvalid && s_arready) rd_state_d = RdData;
            RdData: if (s_rvalid && s_rready && s_rlast) begin
                rd_state_d = RdIdle;
                rd_last_d  = rd_gnt_q;
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Read path routing; everything stays 0 outside the owning state.
    always_comb begin
        s_arvalid  = 1'b0;
        s_arid     = '0;
        s_araddr   = '0;
        s_arlen    = '0;
        s_arsize   = '0;
        s_arburst  = '0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rid     = '0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rlast   = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rid     = '0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rlast   = 1'b0;
        unique case (rd_state_q)
            RdAddr: begin
                s_arvalid  = rd_gnt_q ? m1_arvalid : m0_arvalid;
                s_arid     = rd_gnt_q ? m1_arid    : m0_arid;
                s_araddr   = rd_gnt_q ? m1_araddr  : m0_araddr;
                s_arlen    = rd_gnt_q ? m1_arlen   : m0_arlen;
                s_arsize   = rd_gnt_q ? m1_arsize  : m0_arsize;
                s_arburst  = rd_gnt_q ? m1_arburst : m0_arburst;
                m0_arready = ~rd_gnt_q & s_arready;
                m1_arready = rd_gnt_q & s_arready;
            end
            RdData: begin
                s_rready = rd_gnt_q ? m1_rready : m0_rready;
                if (rd_gnt_q) begin
                    m1_rvalid = s_rvalid;
                    m1_rid    = s_rid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    m1_rlast  = s_rlast;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rid    = s_rid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    m0_rlast  = s_rlast;
                end
            end
            default: ;
        endcase
    end

    // Write path next state
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_last_d  = wr_last_q;
        unique case (wr_state_q)
            WrIdle: if (m0_awvalid || m1_awvalid) begin
                wr_gnt_d   = wr_pick;
                wr_state_d = WrAddr;
            end
            WrAddr: if (s_awvalid && s_awready) wr_state_d = WrData;
            WrData: if (s_wvalid && s_wready && s_wlast) wr_state_d = WrResp;
            WrResp: if (s_bvalid && s_bready) begin
                wr_state_d = WrIdle;
                wr_last_d  = wr_gnt_q;
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Write path routing; W is refused until the address has been accepted.
    always_comb begin
        s_awvalid  = 1'b0;
        s_awid     = '0;
        s_awaddr   = '0;
        s_awlen    = '0;
        s_awsize   = '0;
        s_awburst  = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m0_bid     = '0;
        m0_bresp   = '0;
        m1_bvalid  = 1'b0;
        m1_bid     = '0;
        m1_bresp   = '0;
        unique case (wr_state_q)
            WrAddr: begin
                s_awvalid  = wr_gnt_q ? m1_awvalid : m0_awvalid;
                s_awid     = wr_gnt_q ? m1_awid    : m0_awid;
                s_awaddr   = wr_gnt_q ? m1_awaddr  : m0_awaddr;
                s_awlen    = wr_gnt_q ? m1_awlen   : m0_awlen;
                s_awsize   = wr_gnt_q ? m1_awsize  : m0_awsize;
                s_awburst  = wr_gnt_q ? m1_awburst : m0_awburst;
                m0_awready = ~wr_gnt_q & s_awready;
                m1_awready = wr_gnt_q & s_awready;
            end
            WrData: begin
                s_wvalid  = wr_gnt_q ? m1_wvalid : m0_wvalid;
                s_wdata   = wr_gnt_q ? m1_wdata  : m0_wdata;
                s_wstrb   = wr_gnt_q ? m1_wstrb  : m0_wstrb;
                s_wlast   = wr_gnt_q ? m1_wlast  : m0_wlast;
                m0_wready = ~wr_gnt_q & s_wready;
                m1_wready = wr_gnt_q & s_wready;
            end
            WrResp: begin
                s_bready = wr_gnt_q ? m1_bready : m0_bready;
                if (wr_gnt_q) begin
                    m1_bvalid = s_bvalid;
                    m1_bid    = s_bid;
                    m1_bresp  = s_bresp;
                end else begin
                    m0_bvalid = s_bvalid;
                    m0_bid    = s_bid;
                    m0_bresp  = s_bresp;
                end
            end
            default: ;
        endcase
    end

endmodule
